// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, state encoding and opcode helpers for the EX-stage mul/div unit.
package ex_muldiv_pkg;

   localparam int DATA_W   = 32;
   localparam int ALU_OP_W = 8;

   localparam logic [ALU_OP_W-1:0] ALU_MUL   = 8'h30;
   localparam logic [ALU_OP_W-1:0] ALU_MULH  = 8'h31;
   localparam logic [ALU_OP_W-1:0] ALU_MULHU = 8'h32;
   localparam logic [ALU_OP_W-1:0] ALU_DIV   = 8'h33;
   localparam logic [ALU_OP_W-1:0] ALU_MOD   = 8'h34;
   localparam logic [ALU_OP_W-1:0] ALU_DIVU  = 8'h35;
   localparam logic [ALU_OP_W-1:0] ALU_MODU  = 8'h36;

   typedef enum logic [1:0] {
      MULDIV_IDLE = 2'd0,
      MULDIV_MUL  = 2'd1,
      MULDIV_DIV  = 2'd2,
      MULDIV_DONE = 2'd3
   } muldiv_state_e;

   function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
   endfunction

   function automatic logic is_signed_div(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

   // Quotient-producing ops; every other div-class op returns the remainder.
   function automatic logic is_quo_op(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Iterative restoring divider on operand magnitudes with a final sign fix.
module ex_muldiv_div_core
   import ex_muldiv_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              abort,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int CNT_W = $clog2(DIV_ITER);

   logic              busy;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] quo, rem, dvs;
   logic              neg_q, neg_r;
   logic [DATA_W:0]   rem_sh, diff;
   logic [DATA_W-1:0] quo_n, rem_n;

   function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] v, input logic neg);
      return neg ? (~v + DATA_W'(1)) : v;
   endfunction

   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
      return fix_sign(v, sgn & v[DATA_W-1]);
   endfunction

   // One restoring step: shift {rem, quo} left, trial-subtract, keep or restore.
   always_comb begin
      rem_sh = {rem, quo[DATA_W-1]};
      diff   = rem_sh - {1'b0, dvs};
      quo_n  = {quo[DATA_W-2:0], 1'b0};
      rem_n  = rem_sh[DATA_W-1:0];
      if (!diff[DATA_W]) begin
         rem_n    = diff[DATA_W-1:0];
         quo_n[0] = 1'b1;
      end
   end

   assign done      = busy && (cnt == CNT_W'(DIV_ITER - 1));
   assign quotient  = fix_sign(quo_n, neg_q);
   assign remainder = fix_sign(rem_n, neg_r);

   // Operand load, iteration and counter; abort discards everything in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy  <= 1'b0;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         busy  <= 1'b1;
         cnt   <= '0;
         quo   <= magnitude(dividend, is_signed);
         dvs   <= magnitude(divisor, is_signed);
         rem   <= '0;
         neg_q <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
         neg_r <= is_signed & dividend[DATA_W-1];
      end else if (busy) begin
         quo <= quo_n;
         rem <= rem_n;
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit: control FSM, multiplier and result select.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                exception_flush,
   input  logic                downstream_stall,
   input  logic                start,
   input  logic [ALU_OP_W-1:0] aluop,
   input  logic [DATA_W-1:0]   reg1,
   input  logic [DATA_W-1:0]   reg2,
   output logic                stall_req,
   output logic [DATA_W-1:0]   result,
   output logic                result_valid
);

   muldiv_state_e state, state_n;

   logic [ALU_OP_W-1:0]      op_q;
   logic [DATA_W-1:0]        op_a, op_b;
   logic                     div_load, div_abort, div_done;
   logic [DATA_W-1:0]        div_quo, div_rem;
   logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
   logic [DATA_W-1:0]        mul_res;

   ex_muldiv_div_core #(.DIV_ITER(DIV_ITER)) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .abort     (div_abort),
      .is_signed (is_signed_div(aluop)),
      .dividend  (reg1),
      .divisor   (reg2),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Single-cycle product from the latched operands; MULH.WU zero-extends.
   always_comb begin
      if (op_q == ALU_MULHU) begin
         a_ext = {{DATA_W{1'b0}}, op_a};
         b_ext = {{DATA_W{1'b0}}, op_b};
      end else begin
         a_ext = {{DATA_W{op_a[DATA_W-1]}}, op_a};
         b_ext = {{DATA_W{op_b[DATA_W-1]}}, op_b};
      end
      prod    = a_ext * b_ext;
      mul_res = (op_q == ALU_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= MULDIV_IDLE;
      else      state <= state_n;
   end

   // Next state, divider handshake and pause request; flush beats everything.
   always_comb begin
      state_n   = state;
      div_load  = 1'b0;
      div_abort = exception_flush | ~start;
      stall_req = rst & start & (state != MULDIV_DONE) & ~exception_flush;
      if (exception_flush) begin
         state_n = MULDIV_IDLE;
      end else begin
         case (state)
            MULDIV_IDLE: begin
               if (start) begin
                  if (is_mul_op(aluop)) begin
                     state_n = MULDIV_MUL;
                  end else if (reg2 == '0) begin
                     state_n = MULDIV_DONE;
                  end else begin
                     state_n  = MULDIV_DIV;
                     div_load = 1'b1;
                  end
               end
            end
            MULDIV_MUL:  state_n = start ? MULDIV_DONE : MULDIV_IDLE;
            MULDIV_DIV: begin
               if (!start)        state_n = MULDIV_IDLE;
               else if (div_done) state_n = MULDIV_DONE;
            end
            MULDIV_DONE: if (!downstream_stall) state_n = MULDIV_IDLE;
            default:     state_n = MULDIV_IDLE;
         endcase
      end
   end

   // Operand latch, result capture on entry to DONE, and the valid flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q         <= '0;
         op_a         <= '0;
         op_b         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= (state_n == MULDIV_DONE);
         if (state == MULDIV_IDLE && start && !exception_flush) begin
            op_q <= aluop;
            op_a <= reg1;
            op_b <= reg2;
         end
         if (state_n == MULDIV_DONE) begin
            case (state)
               MULDIV_IDLE: result <= is_quo_op(aluop) ? '1 : reg1;
               MULDIV_MUL:  result <= mul_res;
               MULDIV_DIV:  result <= is_quo_op(op_q) ? div_quo : div_rem;
               default:     result <= result;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed table, corner sequences, random ops vs. model.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        exception_flush = 1'b0;
   logic        downstream_stall = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  aluop = '0;
   logic [31:0] reg1 = '0;
   logic [31:0] reg2 = '0;
   logic        stall_req;
   logic [31:0] result;
   logic        result_valid;

   int checks = 0;
   int failures = 0;

   ex_muldiv #(.DIV_ITER(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .exception_flush  (exception_flush),
      .downstream_stall (downstream_stall),
      .start            (start),
      .aluop            (aluop),
      .reg1             (reg1),
      .reg2             (reg2),
      .stall_req        (stall_req),
      .result           (result),
      .result_valid     (result_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      int          hold;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Architectural result computed with wide plain arithmetic.
   function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = 0;
      case (op)
         ALU_MUL:   p = sa * sb;
         ALU_MULH:  begin p = sa * sb; p = p >>> 32; end
         ALU_MULHU: begin p = ua * ub; p = p >> 32; end
         ALU_DIV:   p = (b == 0) ? -1 : sa / sb;
         ALU_MOD:   p = (b == 0) ? sa : sa % sb;
         ALU_DIVU:  p = (b == 0) ? -1 : ua / ub;
         ALU_MODU:  p = (b == 0) ? ua : ua % ub;
         default:   p = 0;
      endcase
      return p[31:0];
   endfunction

   function automatic int ref_latency(input logic [7:0] op, input logic [31:0] b);
      if (op == ALU_MUL || op == ALU_MULH || op == ALU_MULHU) return 2;
      if (b == 0) return 1;
      return 33;
   endfunction

   // Issue one op at cycle T, wait for result_valid, check latency/result, optionally stall in DONE.
   task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int hold);
      int   n;
      logic stall_ok;
      @(posedge clk); #1;
      aluop = op; reg1 = a; reg2 = b; start = 1'b1;
      @(negedge clk);
      check({name, "_stall_T"}, {31'd0, stall_req}, 32'd1);
      n = 0;
      stall_ok = 1'b1;
      while (!result_valid && n < 60) begin
         @(posedge clk); @(negedge clk);
         n++;
         if (!result_valid && !stall_req) stall_ok = 1'b0;
      end
      check({name, "_latency"}, 32'(n), 32'(exp_lat));
      check({name, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
      check({name, "_result"}, result, exp_res);
      check({name, "_stall_done"}, {31'd0, stall_req}, 32'd0);
      if (hold > 0) begin
         downstream_stall = 1'b1;
         for (int k = 1; k <= hold; k++) begin
            @(posedge clk); @(negedge clk);
            check({name, "_hold_valid"}, {31'd0, result_valid}, 32'd1);
            check({name, "_hold_result"}, result, exp_res);
            check({name, "_hold_stall"}, {31'd0, stall_req}, 32'd0);
         end
         downstream_stall = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check({name, "_valid_fall"}, {31'd0, result_valid}, 32'd0);
   endtask

   // Watch a window and report whether result_valid ever rose.
   task automatic expect_no_valid(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
      end
      check({name, "_no_valid"}, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      tbl[0]  = '{ALU_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2,  0};
      tbl[1]  = '{ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2,  0};
      tbl[2]  = '{ALU_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2,  0};
      tbl[3]  = '{ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0};
      tbl[4]  = '{ALU_MOD,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0};
      tbl[5]  = '{ALU_DIVU,  32'd100,      32'd7,        32'd14,       33, 0};
      tbl[6]  = '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0};
      tbl[7]  = '{ALU_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 0};
      tbl[8]  = '{ALU_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1,  0};
      tbl[9]  = '{ALU_MODU,  32'd5,        32'd0,        32'd5,        1,  0};
      tbl[10] = '{ALU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  0};
      tbl[11] = '{ALU_MOD,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  0};
      tbl[12] = '{ALU_MUL,   32'd3,        32'd4,        32'd12,       2,  3};
      tbl[13] = '{ALU_MODU,  32'd100,      32'd7,        32'd2,        33, 0};

      // Reset with start high: stall_req must be forced low and all outputs cleared.
      start = 1'b1; aluop = ALU_MUL; reg1 = 32'd9; reg2 = 32'd9;
      repeat (3) @(negedge clk);
      check("reset_stall", {31'd0, stall_req}, 32'd0);
      check("reset_valid", {31'd0, result_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      start = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, tbl[i].hold);

      // Flush during DIV counter cycle 10.
      @(posedge clk); #1;
      aluop = ALU_DIV; reg1 = 32'd1000; reg2 = 32'd3; start = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      exception_flush = 1'b1;
      #1;
      check("flush_stall", {31'd0, stall_req}, 32'd0);
      @(posedge clk); #1;
      exception_flush = 1'b0;
      start = 1'b0;
      expect_no_valid("flush", 40);
      run_op("after_flush", ALU_DIVU, 32'd81, 32'd9, 32'd9, 33, 0);

      // start dropping mid-DIV aborts the operation.
      @(posedge clk); #1;
      aluop = ALU_DIVU; reg1 = 32'd50; reg2 = 32'd5; start = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b0;
      expect_no_valid("drop_start", 40);

      // Asynchronous reset mid-DIV with a nonzero result held from a previous op.
      run_op("pre_reset", ALU_MUL, 32'd6, 32'd7, 32'd42, 2, 0);
      @(posedge clk); #1;
      aluop = ALU_DIVU; reg1 = 32'd1234; reg2 = 32'd10; start = 1'b1;
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midreset_stall", {31'd0, stall_req}, 32'd0);
      check("midreset_valid", {31'd0, result_valid}, 32'd0);
      check("midreset_result", result, 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      run_op("after_reset", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

      // Randomized ops against the reference model.
      for (int i = 0; i < 30; i++) begin
         logic [7:0]  op;
         logic [31:0] a, b;
         case ($urandom_range(0, 6))
            0: op = ALU_MUL;
            1: op = ALU_MULH;
            2: op = ALU_MULHU;
            3: op = ALU_DIV;
            4: op = ALU_MOD;
            5: op = ALU_DIVU;
            default: op = ALU_MODU;
         endcase
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFFFFFF - $urandom_range(0, 15);
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), op, a, b, ref_result(op, a, b), ref_latency(op, b), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
